// File: rtl/serial_adder_n_pkg.sv
// rtl/serial_adder_n_pkg.sv - shared types and constants for the bit-serial adder
package serial_adder_n_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic RST_ACT = 1'b0;

endpackage

// File: rtl/serial_adder_n_if.sv
// rtl/serial_adder_n_if.sv - operand/result handshake bundle for the bit-serial adder
interface serial_adder_n_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         sub;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         co;
    logic         ovf;

    modport master (
        output start, a, b, ci, sub,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, a, b, ci, sub,
        output busy, done, s, co, ovf
    );
endinterface

// File: rtl/serial_adder_n_fa_bit.sv
// rtl/serial_adder_n_fa_bit.sv - one-bit combinational full adder cell
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial N-bit adder/subtractor, LSB first, one bit per clock
module serial_adder_n
    import serial_adder_n_pkg::*;
#(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_adder_n_if.slave bus
);
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     a_sh;
    logic [N-1:0]     b_sh;
    logic [N-1:0]     s_sh;
    logic             carry;
    logic             busy_r;
    logic             done_r;
    logic [N-1:0]     s_r;
    logic             co_r;
    logic             ovf_r;

    logic             fa_s;
    logic             fa_co;
    logic [N-1:0]     s_next;

    fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum bits enter at the MSB so after N shifts bit 0 sits at the LSB.
    assign s_next = {fa_s, s_sh[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst_n == RST_ACT) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            s_r    <= '0;
            co_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1 with the borrow-in folded into the initial carry.
                        a_sh   <= bus.a;
                        b_sh   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.ci ^ bus.sub;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    carry <= fa_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB on this edge.
                        s_r    <= s_next;
                        co_r   <= fa_co;
                        ovf_r  <= carry ^ fa_co;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.s    = s_r;
    assign bus.co   = co_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - directed self-checking bench for serial_adder_n
module tb_serial_adder_n;
    localparam int N = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_adder_n_if #(.N(N)) bus ();

    serial_adder_n #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic civ, input logic subv);
        bus.a     = av;
        bus.b     = bv;
        bus.ci    = civ;
        bus.sub   = subv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        bus.ci    = ~civ;
        bus.sub   = ~subv;
        check("accept_busy", {31'd0, bus.busy}, 32'd1);
        check("accept_done", {31'd0, bus.done}, 32'd0);
    endtask

    // Called right after the accepting edge; returns once done is seen or the budget runs out.
    task automatic wait_done(input string tag, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        int busy_cnt;
        int overlap;
        n        = 0;
        busy_cnt = 1;
        overlap  = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
            if (bus.busy) busy_cnt++;
            if (bus.busy && bus.done) overlap++;
        end
        check({tag, "_latency"}, n, N);
        check({tag, "_busycnt"}, busy_cnt, N);
        check({tag, "_overlap"}, overlap, 0);
        check({tag, "_s"}, {24'd0, bus.s}, {24'd0, es});
        check({tag, "_co"}, {31'd0, bus.co}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
    endtask

    initial begin
        int seen;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.ci    = 1'b0;
        bus.sub   = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_s", {24'd0, bus.s}, 32'd0);
        check("rst_co", {31'd0, bus.co}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        rst_n = 1'b1;
        tick();

        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_done("add_ovf", 8'h96, 1'b0, 1'b1);
        tick();
        check("done_pulse_width", {31'd0, bus.done}, 32'd0);
        check("hold_s", {24'd0, bus.s}, 32'h96);

        launch(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done("wrap", 8'h00, 1'b1, 1'b0);
        tick();

        launch(8'h7F, 8'h7F, 1'b1, 1'b0);
        wait_done("carry_in", 8'hFF, 1'b0, 1'b1);
        tick();

        launch(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done("sub_borrow", 8'hF0, 1'b0, 1'b0);
        tick();

        launch(8'h01, 8'h01, 1'b0, 1'b0);
        tick();
        tick();
        bus.a     = 8'hAA;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        // two cycles already consumed after the accept; wait_done counts from there
        begin
            int n;
            n = 3;
            while (!bus.done && n < 40) begin
                tick();
                n++;
            end
            check("midrun_latency", n, N);
        end
        check("midrun_s", {24'd0, bus.s}, 32'h02);
        check("midrun_co", {31'd0, bus.co}, 32'd0);

        bus.a     = 8'h03;
        bus.b     = 8'h04;
        bus.ci    = 1'b0;
        bus.sub   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b_busy", {31'd0, bus.busy}, 32'd1);
        check("b2b_done_low", {31'd0, bus.done}, 32'd0);
        check("b2b_hold_s", {24'd0, bus.s}, 32'h02);
        wait_done("b2b", 8'h07, 1'b0, 1'b0);
        tick();

        launch(8'h22, 8'h11, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_s", {24'd0, bus.s}, 32'd0);
        check("midrst_co", {31'd0, bus.co}, 32'd0);
        check("midrst_ovf", {31'd0, bus.ovf}, 32'd0);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        check("midrst_no_done", seen, 0);

        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_done("after_rst", 8'h96, 1'b0, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
